// File: rtl/user_code_loader_pkg.sv
// Shared types and defaults for the i281 user code loader.
package i281_loader_pkg;

   localparam int WORD_W_DEF    = 16;
   localparam int ADDR_W_DEF    = 5;
   localparam int DEPTH_DEF     = 32;
   // mem_addr bit that selects the High bank; the low bits index the word.
   localparam int HIGH_BANK_BIT = 4;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      WR,
      CHK,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/user_code_loader_if.sv
// Byte link (UART RX side) and code memory write port of the loader.
// master: the loader (accepts bytes, drives memory writes).
// slave:  the surroundings (byte source and writable code memory).
interface user_code_loader_if #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 5
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/user_code_loader_checksum.sv
// 8-bit wrap-around byte accumulator for the load image checksum.
// zero_next flags that adding byte_in to the running sum gives 0 mod 256.
module user_code_checksum (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] byte_in,
   output logic       zero_next
);

   logic [7:0] sum;

   // Running sum: clear wins over add so a restart always starts from 0.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!reset_n) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (add) begin
         sum <= sum + byte_in;
      end
   end

   assign zero_next = (8'(sum + byte_in) == 8'd0);

endmodule

// File: rtl/user_code_loader.sv
// Run-time loader for the i281 user code memory. Holds the CPU in reset,
// packs incoming byte pairs into 16-bit words written in address order and
// verifies a trailing 8-bit checksum byte before releasing the CPU.
module user_code_loader
   import i281_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                load_start,
   user_code_loader_if.master  bus,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_loaded
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        hi_byte;
   logic [WORD_W-1:0] wdata_q;
   logic [ADDR_W:0]   count;
   logic              rx_ready_c;
   logic              accept;
   logic              zero_next;

   // A restart pulse blocks byte acceptance in the same cycle.
   assign rx_ready_c = (state == HI || state == LO || state == CHK) && !load_start;
   assign accept     = bus.rx_valid && rx_ready_c;

   user_code_checksum u_checksum (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (load_start),
      .add       (accept && (state == HI || state == LO)),
      .byte_in   (bus.rx_data),
      .zero_next (zero_next)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and status outputs; load_start overrides any transition.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_n    = state;
      bus.mem_we = 1'b0;
      busy       = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: ;
         HI: begin
            busy     = 1'b1;
            cpu_hold = 1'b1;
            if (accept) state_n = LO;
         end
         LO: begin
            busy     = 1'b1;
            cpu_hold = 1'b1;
            if (accept) state_n = WR;
         end
         WR: begin
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            bus.mem_we = 1'b1;
            state_n    = (addr == LAST_ADDR) ? CHK : HI;
         end
         CHK: begin
            busy     = 1'b1;
            cpu_hold = 1'b1;
            if (accept) state_n = zero_next ? DONE : ERR;
         end
         DONE: done = 1'b1;
         ERR: begin
            error    = 1'b1;
            cpu_hold = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (load_start) state_n = HI;
   end

   // Byte packing, write address/data hold registers and word counter.
   // The memory-facing registers load only when the low byte arrives so the
   // write port holds its last values outside the WR cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr    <= '0;
         addr_q  <= '0;
         hi_byte <= '0;
         wdata_q <= '0;
         count   <= '0;
      end else if (load_start) begin
         addr  <= '0;
         count <= '0;
      end else begin
         if (state == HI && accept) begin
            hi_byte <= bus.rx_data;
         end
         if (state == LO && accept) begin
            wdata_q <= {hi_byte, bus.rx_data};
            addr_q  <= addr;
         end
         if (state == WR) begin
            count <= count + 1'b1;
            if (addr != LAST_ADDR) addr <= addr + 1'b1;
         end
      end
   end

   assign bus.rx_ready  = rx_ready_c;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign words_loaded  = count;

endmodule

// File: tb/tb_user_code_loader.sv
// Self-checking bench for user_code_loader: stimulus pushes expected memory
// writes into a scoreboard queue, a monitor pops and compares on every mem_we.
module tb_user_code_loader;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       load_start = 1'b0;
   logic       cpu_hold, busy, done, error;
   logic [5:0] words_loaded;

   user_code_loader_if #(.WORD_W(16), .ADDR_W(5)) bus ();

   user_code_loader dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .load_start   (load_start),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] img[32];
   int          tests = 0;
   int          fails = 0;
   bit          bp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every write must match the oldest expected write.
   always @(negedge clock) begin
      if (reset_n && bus.mem_we) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
            check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
         end
         check("rx_ready_in_wr", 32'(bus.rx_ready), 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit taken = 1'b0;
      int n = 0;
      while (!taken && n < 200) begin
         @(negedge clock);
         bus.rx_data  = b;
         bus.rx_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         taken = bus.rx_valid && bus.rx_ready;
         @(posedge clock);
         #1;
         bus.rx_valid = 1'b0;
         n++;
      end
      check("byte_accept", 32'(taken), 32'd1);
   endtask

   // Sends one word and checks the write strobe appears the cycle after the low byte.
   task automatic send_word(input logic [4:0] a, input logic [15:0] w);
      exp_q.push_back('{addr: a, data: w});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      @(negedge clock);
      check("we_latency", 32'(bus.mem_we), 32'd1);
      check("cpu_hold_loading", 32'(cpu_hold), 32'd1);
      check("busy_loading", 32'(busy), 32'd1);
   endtask

   task automatic start_load();
      @(negedge clock);
      load_start = 1'b1;
      #1;
      check("rx_ready_on_start", 32'(bus.rx_ready), 32'd0);
      @(posedge clock);
      #1;
      load_start   = 1'b0;
      bus.rx_valid = 1'b0;
   endtask

   // Checksum byte that makes the image bytes sum to 0 mod 256.
   function automatic logic [7:0] good_csum(input int first, input int last);
      int s = 0;
      for (int k = first; k <= last; k++) s += img[k][15:8] + img[k][7:0];
      return 8'((256 - (s % 256)) % 256);
   endfunction

   task automatic check_end(input bit good);
      @(negedge clock);
      check("end_busy", 32'(busy), 32'd0);
      check("end_done", 32'(done), 32'(good));
      check("end_error", 32'(error), 32'(!good));
      check("end_cpu_hold", 32'(cpu_hold), 32'(!good));
      check("end_words", 32'(words_loaded), 32'd32);
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load_image(input logic [7:0] delta);
      start_load();
      for (int k = 0; k < 32; k++) send_word(5'(k), img[k]);
      send_byte(good_csum(0, 31) + delta);
      check_end(delta == 8'd0);
   endtask

   // Presents 8'hFF while no load is running; nothing may change.
   task automatic idle_bytes(input logic exp_done);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'hFF;
         #1;
         check("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'(exp_done));
      end
      @(negedge clock);
      bus.rx_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      check({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Reset state.
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Bytes with no load running are ignored.
      idle_bytes(1'b0);

      // Good load with the reference image.
      for (int k = 0; k < 32; k++) img[k] = {8'(k), 8'hA5 ^ 8'(k)};
      load_image(8'd0);
      idle_bytes(1'b1);

      // Same image, checksum off by one.
      load_image(8'd1);

      // Random image under random back-pressure.
      for (int k = 0; k < 32; k++) img[k] = 16'($urandom);
      bp = 1'b1;
      load_image(8'd0);
      bp = 1'b0;

      // Restart after 5 words with a byte offered in the restart cycle.
      for (int k = 0; k < 32; k++) img[k] = 16'($urandom);
      start_load();
      for (int k = 0; k < 5; k++) send_word(5'(k), 16'($urandom));
      @(negedge clock);
      load_start   = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
      #1;
      check("restart_rx_ready", 32'(bus.rx_ready), 32'd0);
      @(posedge clock);
      #1;
      load_start   = 1'b0;
      bus.rx_valid = 1'b0;
      check("restart_words", 32'(words_loaded), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      send_word(5'd0, img[0]);
      @(posedge clock);
      #1;
      check("restart_count1", 32'(words_loaded), 32'd1);
      for (int k = 1; k < 32; k++) send_word(5'(k), img[k]);
      send_byte(good_csum(0, 31));
      check_end(1'b1);

      // Asynchronous reset in the middle of a load.
      start_load();
      for (int k = 0; k < 3; k++) send_word(5'(k), img[k]);
      send_byte(img[3][15:8]);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clock);
      reset_n = 1'b1;
      check("async_reset_queue", 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge clock);
      check("after_reset_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
